riscv_wb_stage: RTL and testbench
=================================

RISCV_WB_STAGE -- requirements
Module: riscv_wb_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; port names are i_clk and i_rst.
REQ-002 i_clk  in  1  rising-edge clock; all state in this block updates on posedge.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 i_wb_alu_valid / o_wb_alu_ready  in/out  1/1  ALU result handshake; a result transfers when both are high.
REQ-005 i_wb_alu_rd_addr, i_wb_alu_data  in  5/`XLEN  ALU destination register and result.
REQ-006 i_wb_ld_issue, i_wb_ld_issue_rd_addr  in  1/5  a load was issued this cycle to the given rd.
REQ-007 i_wb_ld_rsp_valid  in  1  load data returned this cycle; there is no backpressure on this input.
REQ-008 i_wb_ld_rsp_data, i_wb_ld_rsp_funct3, i_wb_ld_rsp_byte_offset, i_wb_ld_rsp_rd_addr  in  `XLEN/3/2/5  raw aligned word, load type, address[1:0] and rd.
REQ-009 o_regfile_rd_data, o_regfile_rd_addr, o_regfile_rd_wen  out  `XLEN/5/1  registered register-file write port.
REQ-010 i_wb_rs1_addr, i_wb_rs2_addr / o_wb_rs1_busy, o_wb_rs2_busy  in/out  5/1  decode scoreboard queries.
REQ-011 o_wb_ld_pending  out  1  high while any scoreboard bit is set.
REQ-012 o_wb_err  out  1  sticky protocol/decode error flag.

Function
REQ-013 Load response SHALL have priority over ALU: o_wb_alu_ready = !i_wb_ld_rsp_valid (combinational).
REQ-014 Latency SHALL be one cycle: data accepted at edge N appears on o_regfile_* after edge N and is held for the whole cycle, so the register file's negedge write lands mid-cycle N+1.
REQ-015 o_regfile_rd_wen SHALL be 1 only when a transfer occurred and rd != 0; with no transfer, wen SHALL be 0 and data/addr hold their previous values.
REQ-016 Load extension: LB 000 and LH 001 sign-extend; LW 010 passes through; LBU 100 and LHU 101 zero-extend. The byte lane is selected by byte_offset; halfword uses offset[1] only; word ignores offset.
REQ-017 Any other funct3 SHALL write 0 to rd (wen per REQ-015) and set o_wb_err.
REQ-018 Scoreboard SHALL have 32 busy bits; bit 0 is never set.
- Issue sets bit[issue_rd].
- Load response clears bit[rsp_rd].
REQ-019 If the same rd is issued and responded in the same cycle, the bit SHALL remain set (the new load wins).
REQ-020 Issue to an already-busy rd, or a response to a non-busy rd (rd != 0), SHALL set o_wb_err; the scoreboard SHALL still apply REQ-018.
REQ-021 o_wb_rsN_busy = bit[rsN_addr] (combinational); address 0 always returns 0.
REQ-022 o_wb_ld_pending SHALL be the OR of all busy bits (current state).

Reset
REQ-023 On i_rst at a posedge the block SHALL clear o_regfile_rd_data, o_regfile_rd_addr, o_regfile_rd_wen, all busy bits and o_wb_err; inputs in that cycle SHALL be ignored.
REQ-024 Reset asserted with loads outstanding SHALL drop them: later responses to those rds set o_wb_err per REQ-020 but still write.
REQ-025 o_wb_alu_ready SHALL follow REQ-013 during reset, but no transfer takes effect.

Configuration
REQ-026 Macro RISCV_WB_SB_BYPASS_EN:
- Defined: o_wb_rsN_busy SHALL read 0 when i_wb_ld_rsp_valid is high and rsp_rd equals rsN_addr in the same cycle (clear-bypass).
- Undefined: busy reflects registered state only, and decode sees the clear one cycle later.

Structure
REQ-027 `XLEN and load funct3 codes (LB/LH/LW/LBU/LHU) SHALL be defined in riscv_configs.v and included under the NOINC guard.
REQ-028 Load extension SHALL be a combinational sub-module riscv_load_ext (inputs: word, funct3, offset; outputs: data, illegal).

Verification
REQ-029 ALU valid, rd=5, data=0x1234_5678, no load -> next cycle wen=1, addr=5, data=0x1234_5678.
REQ-030 LB, offset=3, word=0x80FF_0000 -> data 0xFFFF_FF80; LHU, offset=2, word=0xBEEF_0000 -> data 0x0000_BEEF.
REQ-031 ALU valid and load response in the same cycle -> alu_ready=0, load written first, ALU written the following cycle.
REQ-032 Issue rd=7; query rs1=7 -> busy=1 until the response cycle; same-cycle busy is 0 only with RISCV_WB_SB_BYPASS_EN.
REQ-033 ALU rd=0, data=0xFFFF_FFFF -> wen=0; funct3=011 response -> data 0 and o_wb_err=1, sticky until i_rst.
REQ-034 Issue rd=9, then assert i_rst -> busy[9]=0, ld_pending=0; a later response for rd=9 sets o_wb_err.

Source files
------------

// File: rtl/riscv_wb_stage_pkg.sv
// riscv_wb_stage_pkg -- types and helpers shared by the writeback stage.
`ifndef NOINC
`include "riscv_configs.v"
`endif

package riscv_wb_stage_pkg;

    localparam int XLEN     = `XLEN;
    localparam int NUM_REGS = 32;

    typedef logic [4:0]          reg_addr_t;
    typedef logic [XLEN-1:0]     xlen_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    // One register-file write port beat.
    typedef struct packed {
        xlen_t     data;
        reg_addr_t addr;
        logic      wen;
    } rf_write_t;

    // One-hot register mask, all zero when en is low.
    function automatic reg_mask_t reg_onehot(input logic en, input reg_addr_t addr);
        reg_onehot = '0;
        if (en) reg_onehot[addr] = 1'b1;
    endfunction

endpackage

// File: rtl/riscv_wb_stage_if.sv
// riscv_wb_stage_if -- bundle of all writeback-stage signals except clock and reset.
// master = execute/LSU/decode side, slave = the writeback stage itself.
`ifndef NOINC
`include "riscv_configs.v"
`endif

interface riscv_wb_stage_if;
    import riscv_wb_stage_pkg::*;

    logic      i_wb_alu_valid;
    logic      o_wb_alu_ready;
    reg_addr_t i_wb_alu_rd_addr;
    xlen_t     i_wb_alu_data;

    logic      i_wb_ld_issue;
    reg_addr_t i_wb_ld_issue_rd_addr;

    logic      i_wb_ld_rsp_valid;
    xlen_t     i_wb_ld_rsp_data;
    logic [2:0] i_wb_ld_rsp_funct3;
    logic [1:0] i_wb_ld_rsp_byte_offset;
    reg_addr_t i_wb_ld_rsp_rd_addr;

    xlen_t     o_regfile_rd_data;
    reg_addr_t o_regfile_rd_addr;
    logic      o_regfile_rd_wen;

    reg_addr_t i_wb_rs1_addr;
    reg_addr_t i_wb_rs2_addr;
    logic      o_wb_rs1_busy;
    logic      o_wb_rs2_busy;

    logic      o_wb_ld_pending;
    logic      o_wb_err;

    modport master (
        output i_wb_alu_valid, i_wb_alu_rd_addr, i_wb_alu_data,
        output i_wb_ld_issue, i_wb_ld_issue_rd_addr,
        output i_wb_ld_rsp_valid, i_wb_ld_rsp_data, i_wb_ld_rsp_funct3,
        output i_wb_ld_rsp_byte_offset, i_wb_ld_rsp_rd_addr,
        output i_wb_rs1_addr, i_wb_rs2_addr,
        input  o_wb_alu_ready, o_regfile_rd_data, o_regfile_rd_addr, o_regfile_rd_wen,
        input  o_wb_rs1_busy, o_wb_rs2_busy, o_wb_ld_pending, o_wb_err
    );

    modport slave (
        input  i_wb_alu_valid, i_wb_alu_rd_addr, i_wb_alu_data,
        input  i_wb_ld_issue, i_wb_ld_issue_rd_addr,
        input  i_wb_ld_rsp_valid, i_wb_ld_rsp_data, i_wb_ld_rsp_funct3,
        input  i_wb_ld_rsp_byte_offset, i_wb_ld_rsp_rd_addr,
        input  i_wb_rs1_addr, i_wb_rs2_addr,
        output o_wb_alu_ready, o_regfile_rd_data, o_regfile_rd_addr, o_regfile_rd_wen,
        output o_wb_rs1_busy, o_wb_rs2_busy, o_wb_ld_pending, o_wb_err
    );

endinterface

// File: rtl/riscv_configs.v
// riscv_configs.v -- shared datapath width and load funct3 encodings.
// Included by every file of the writeback slice unless NOINC is defined.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V

`define XLEN 32

`define LB  3'b000
`define LH  3'b001
`define LW  3'b010
`define LBU 3'b100
`define LHU 3'b101

`endif

// File: rtl/riscv_wb_stage_load_ext.sv
// riscv_load_ext -- combinational load lane select and sign/zero extension.
// Unknown funct3 yields zero data and raises illegal.
`ifndef NOINC
`include "riscv_configs.v"
`endif

module riscv_load_ext
    import riscv_wb_stage_pkg::*;
(
    input  xlen_t      word,
    input  logic [2:0] funct3,
    input  logic [1:0] offset,
    output xlen_t      data,
    output logic       illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte lane; halfwords only look at offset[1].
    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane according to the load type.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            `LB:     data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            `LH:     data = {{(XLEN-16){half_sel[15]}}, half_sel};
            `LW:     data = word;
            `LBU:    data = {{(XLEN-8){1'b0}}, byte_sel};
            `LHU:    data = {{(XLEN-16){1'b0}}, half_sel};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_wb_stage.sv
// riscv_wb_stage -- writeback arbiter (load over ALU), registered register-file
// write port, load scoreboard and sticky error flag.
// Optional macro RISCV_WB_SB_BYPASS_EN: a load response clears the queried busy
// bit combinationally in the same cycle instead of one cycle later.
`ifndef NOINC
`include "riscv_configs.v"
`endif

module riscv_wb_stage
    import riscv_wb_stage_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    riscv_wb_stage_if.slave wb
);

    xlen_t     ld_data;
    logic      ld_illegal;
    logic      alu_xfer;
    reg_mask_t busy_q;
    reg_mask_t clr_mask;
    reg_mask_t set_mask;
    reg_mask_t busy_after_clr;
    reg_mask_t busy_d;
    logic      rsp_orphan;
    logic      issue_conflict;
    logic      err_q;
    logic      rs1_bypass;
    logic      rs2_bypass;
    rf_write_t rf_q;
    rf_write_t rf_d;

    riscv_load_ext u_load_ext (
        .word    (wb.i_wb_ld_rsp_data),
        .funct3  (wb.i_wb_ld_rsp_funct3),
        .offset  (wb.i_wb_ld_rsp_byte_offset),
        .data    (ld_data),
        .illegal (ld_illegal)
    );

    // Load responses cannot be stalled, so they always win the write port.
    assign wb.o_wb_alu_ready = !wb.i_wb_ld_rsp_valid;
    assign alu_xfer          = wb.i_wb_alu_valid && !wb.i_wb_ld_rsp_valid;

    // Clear is applied before set so a same-cycle re-issue to the same rd stays busy;
    // issue conflicts are therefore judged against the post-clear state.
    assign clr_mask       = reg_onehot(wb.i_wb_ld_rsp_valid, wb.i_wb_ld_rsp_rd_addr);
    assign set_mask       = reg_onehot(wb.i_wb_ld_issue, wb.i_wb_ld_issue_rd_addr);
    assign busy_after_clr = busy_q & ~clr_mask;
    assign busy_d         = (busy_after_clr | set_mask) & ~reg_mask_t'(1);

    assign rsp_orphan     = wb.i_wb_ld_rsp_valid && (wb.i_wb_ld_rsp_rd_addr != '0)
                            && !busy_q[wb.i_wb_ld_rsp_rd_addr];
    assign issue_conflict = wb.i_wb_ld_issue && busy_after_clr[wb.i_wb_ld_issue_rd_addr];

    // Select the next register-file beat; wen drops when nothing transfers.
    always_comb begin
        rf_d     = rf_q;
        rf_d.wen = 1'b0;
        if (wb.i_wb_ld_rsp_valid) begin
            rf_d = '{data: ld_data, addr: wb.i_wb_ld_rsp_rd_addr,
                     wen: (wb.i_wb_ld_rsp_rd_addr != '0)};
        end else if (alu_xfer) begin
            rf_d = '{data: wb.i_wb_alu_data, addr: wb.i_wb_alu_rd_addr,
                     wen: (wb.i_wb_alu_rd_addr != '0)};
        end
    end

    // Register the write port, scoreboard and sticky error flag.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (i_rst) begin
            rf_q   <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
            if ((wb.i_wb_ld_rsp_valid && ld_illegal) || rsp_orphan || issue_conflict)
                err_q <= 1'b1;
        end
    end

`ifdef RISCV_WB_SB_BYPASS_EN
    assign rs1_bypass = wb.i_wb_ld_rsp_valid && (wb.i_wb_ld_rsp_rd_addr == wb.i_wb_rs1_addr);
    assign rs2_bypass = wb.i_wb_ld_rsp_valid && (wb.i_wb_ld_rsp_rd_addr == wb.i_wb_rs2_addr);
`else
    assign rs1_bypass = 1'b0;
    assign rs2_bypass = 1'b0;
`endif

    // Bit 0 is never set, so x0 queries read zero without a special case.
    assign wb.o_wb_rs1_busy     = busy_q[wb.i_wb_rs1_addr] && !rs1_bypass;
    assign wb.o_wb_rs2_busy     = busy_q[wb.i_wb_rs2_addr] && !rs2_bypass;
    assign wb.o_wb_ld_pending   = |busy_q;
    assign wb.o_wb_err          = err_q;
    assign wb.o_regfile_rd_data = rf_q.data;
    assign wb.o_regfile_rd_addr = rf_q.addr;
    assign wb.o_regfile_rd_wen  = rf_q.wen;

endmodule

// File: tb/tb_riscv_wb_stage.sv
// tb_riscv_wb_stage -- directed bench with a behavioural model checked every cycle.
`timescale 1ns/1ps

module tb_riscv_wb_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_wb_stage_if wb ();
    riscv_wb_stage dut (.i_clk(clk), .i_rst(rst), .wb(wb));

`ifdef RISCV_WB_SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    // Model state: architectural view of scoreboard, error flag and write port.
    bit          m_busy [32];
    bit          m_err;
    logic [31:0] m_data;
    logic [4:0]  m_addr;
    bit          m_wen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Loaded value from plain shifts and arithmetic.
    function automatic logic [31:0] load_value(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] off, output bit bad);
        int unsigned b;
        int unsigned h;
        b   = (w >> (8 * off)) & 32'hFF;
        h   = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
        bad = 1'b0;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: begin bad = 1'b1; return 32'h0; end
        endcase
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (BYPASS && wb.i_wb_ld_rsp_valid && wb.i_wb_ld_rsp_rd_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit any_busy();
        foreach (m_busy[i]) if (m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic model_update();
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_err  = 1'b0;
            m_data = '0;
            m_addr = '0;
            m_wen  = 1'b0;
            return;
        end
        if (wb.i_wb_ld_rsp_valid) begin
            bit bad;
            logic [4:0] rd;
            rd     = wb.i_wb_ld_rsp_rd_addr;
            m_data = load_value(wb.i_wb_ld_rsp_data, wb.i_wb_ld_rsp_funct3,
                                wb.i_wb_ld_rsp_byte_offset, bad);
            m_addr = rd;
            m_wen  = (rd != 5'd0);
            if (bad) m_err = 1'b1;
            if (rd != 5'd0 && !m_busy[rd]) m_err = 1'b1;
            m_busy[rd] = 1'b0;
        end else if (wb.i_wb_alu_valid) begin
            m_data = wb.i_wb_alu_data;
            m_addr = wb.i_wb_alu_rd_addr;
            m_wen  = (wb.i_wb_alu_rd_addr != 5'd0);
        end else begin
            m_wen = 1'b0;
        end
        if (wb.i_wb_ld_issue) begin
            if (m_busy[wb.i_wb_ld_issue_rd_addr]) m_err = 1'b1;
            if (wb.i_wb_ld_issue_rd_addr != 5'd0) m_busy[wb.i_wb_ld_issue_rd_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        wb.i_wb_alu_valid          = 1'b0;
        wb.i_wb_alu_rd_addr        = '0;
        wb.i_wb_alu_data           = '0;
        wb.i_wb_ld_issue           = 1'b0;
        wb.i_wb_ld_issue_rd_addr   = '0;
        wb.i_wb_ld_rsp_valid       = 1'b0;
        wb.i_wb_ld_rsp_data        = '0;
        wb.i_wb_ld_rsp_funct3      = '0;
        wb.i_wb_ld_rsp_byte_offset = '0;
        wb.i_wb_ld_rsp_rd_addr     = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        wb.i_wb_ld_issue         = 1'b1;
        wb.i_wb_ld_issue_rd_addr = rd;
    endtask

    task automatic rsp(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                       input logic [31:0] w);
        wb.i_wb_ld_rsp_valid       = 1'b1;
        wb.i_wb_ld_rsp_rd_addr     = rd;
        wb.i_wb_ld_rsp_funct3      = f3;
        wb.i_wb_ld_rsp_byte_offset = off;
        wb.i_wb_ld_rsp_data        = w;
    endtask

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (started) begin
            check("rf_data", wb.o_regfile_rd_data, m_data);
            check("rf_addr", 32'(wb.o_regfile_rd_addr), 32'(m_addr));
            check("rf_wen", 32'(wb.o_regfile_rd_wen), 32'(m_wen));
            check("err", 32'(wb.o_wb_err), 32'(m_err));
            check("ld_pending", 32'(wb.o_wb_ld_pending), 32'(any_busy()));
            check("alu_ready", 32'(wb.o_wb_alu_ready), 32'(!wb.i_wb_ld_rsp_valid));
            check("rs1_busy", 32'(wb.o_wb_rs1_busy), 32'(exp_busy(wb.i_wb_rs1_addr)));
            check("rs2_busy", 32'(wb.o_wb_rs2_busy), 32'(exp_busy(wb.i_wb_rs2_addr)));
        end
    end

    initial begin
        logic [2:0]  t_f3   [8];
        logic [1:0]  t_off  [8];
        logic [31:0] t_word [8];
        logic [31:0] t_exp  [8];

        t_f3[0] = 3'b000; t_off[0] = 2'd3; t_word[0] = 32'h80FF_0000; t_exp[0] = 32'hFFFF_FF80;
        t_f3[1] = 3'b101; t_off[1] = 2'd2; t_word[1] = 32'hBEEF_0000; t_exp[1] = 32'h0000_BEEF;
        t_f3[2] = 3'b000; t_off[2] = 2'd0; t_word[2] = 32'h0000_007F; t_exp[2] = 32'h0000_007F;
        t_f3[3] = 3'b100; t_off[3] = 2'd1; t_word[3] = 32'h0000_8000; t_exp[3] = 32'h0000_0080;
        t_f3[4] = 3'b001; t_off[4] = 2'd0; t_word[4] = 32'h1234_8001; t_exp[4] = 32'hFFFF_8001;
        t_f3[5] = 3'b001; t_off[5] = 2'd3; t_word[5] = 32'h7FFF_0000; t_exp[5] = 32'h0000_7FFF;
        t_f3[6] = 3'b010; t_off[6] = 2'd1; t_word[6] = 32'hDEAD_BEEF; t_exp[6] = 32'hDEAD_BEEF;
        t_f3[7] = 3'b100; t_off[7] = 2'd2; t_word[7] = 32'h00A5_0000; t_exp[7] = 32'h0000_00A5;

        idle();
        wb.i_wb_rs1_addr = '0;
        wb.i_wb_rs2_addr = '0;
        rst = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        started = 1'b1;
        check("reset_wen", 32'(wb.o_regfile_rd_wen), 32'd0);
        check("reset_data", wb.o_regfile_rd_data, 32'd0);
        check("reset_err", 32'(wb.o_wb_err), 32'd0);
        check("reset_pending", 32'(wb.o_wb_ld_pending), 32'd0);

        // ALU result with no load activity.
        wb.i_wb_alu_valid   = 1'b1;
        wb.i_wb_alu_rd_addr = 5'd5;
        wb.i_wb_alu_data    = 32'h1234_5678;
        tick();
        idle();
        check("alu_wen", 32'(wb.o_regfile_rd_wen), 32'd1);
        check("alu_addr", 32'(wb.o_regfile_rd_addr), 32'd5);
        check("alu_data", wb.o_regfile_rd_data, 32'h1234_5678);
        tick();
        check("idle_wen", 32'(wb.o_regfile_rd_wen), 32'd0);
        check("idle_hold", wb.o_regfile_rd_data, 32'h1234_5678);

        // Load extension table: issue, then respond the next cycle.
        for (int i = 0; i < 8; i++) begin
            issue(5'(16 + i));
            tick();
            idle();
            rsp(5'(16 + i), t_f3[i], t_off[i], t_word[i]);
            tick();
            idle();
            check("ld_data", wb.o_regfile_rd_data, t_exp[i]);
            check("ld_addr", 32'(wb.o_regfile_rd_addr), 32'(16 + i));
        end
        check("ld_no_err", 32'(wb.o_wb_err), 32'd0);

        // Load and ALU collide: load first, ALU the cycle after.
        issue(5'd6);
        tick();
        idle();
        rsp(5'd6, 3'b010, 2'd0, 32'h0000_0066);
        wb.i_wb_alu_valid   = 1'b1;
        wb.i_wb_alu_rd_addr = 5'd8;
        wb.i_wb_alu_data    = 32'hAAAA_0001;
        #1;
        check("collide_ready", 32'(wb.o_wb_alu_ready), 32'd0);
        tick();
        wb.i_wb_ld_rsp_valid = 1'b0;
        check("collide_ld", wb.o_regfile_rd_data, 32'h0000_0066);
        check("collide_ld_addr", 32'(wb.o_regfile_rd_addr), 32'd6);
        tick();
        idle();
        check("collide_alu", wb.o_regfile_rd_data, 32'hAAAA_0001);
        check("collide_alu_addr", 32'(wb.o_regfile_rd_addr), 32'd8);

        // Scoreboard query on rd=7 across issue and response.
        issue(5'd7);
        tick();
        idle();
        wb.i_wb_rs1_addr = 5'd7;
        #1;
        check("rs1_busy_set", 32'(wb.o_wb_rs1_busy), 32'd1);
        tick();
        tick();
        rsp(5'd7, 3'b010, 2'd0, 32'h0000_0077);
        #1;
        check("rs1_busy_rsp_cycle", 32'(wb.o_wb_rs1_busy), 32'(!BYPASS));
        tick();
        idle();
        check("rs1_busy_clear", 32'(wb.o_wb_rs1_busy), 32'd0);
        check("pending_clear", 32'(wb.o_wb_ld_pending), 32'd0);
        wb.i_wb_rs1_addr = 5'd0;

        // ALU write to x0, then an illegal funct3 response.
        wb.i_wb_alu_valid   = 1'b1;
        wb.i_wb_alu_rd_addr = 5'd0;
        wb.i_wb_alu_data    = 32'hFFFF_FFFF;
        tick();
        idle();
        check("x0_wen", 32'(wb.o_regfile_rd_wen), 32'd0);
        issue(5'd11);
        tick();
        idle();
        rsp(5'd11, 3'b011, 2'd0, 32'h0000_0055);
        tick();
        idle();
        check("illegal_data", wb.o_regfile_rd_data, 32'd0);
        check("illegal_wen", 32'(wb.o_regfile_rd_wen), 32'd1);
        check("illegal_err", 32'(wb.o_wb_err), 32'd1);
        tick();
        tick();
        check("err_sticky", 32'(wb.o_wb_err), 32'd1);

        // Same rd responded and re-issued in one cycle stays busy.
        issue(5'd12);
        tick();
        idle();
        rsp(5'd12, 3'b010, 2'd0, 32'h0000_0012);
        issue(5'd12);
        wb.i_wb_rs2_addr = 5'd12;
        tick();
        idle();
        check("reissue_busy", 32'(wb.o_wb_rs2_busy), 32'd1);
        rsp(5'd12, 3'b010, 2'd0, 32'h0000_0013);
        tick();
        idle();
        check("reissue_clear", 32'(wb.o_wb_rs2_busy), 32'd0);
        wb.i_wb_rs2_addr = 5'd0;

        // Reset with live inputs: ready still follows the response, nothing transfers.
        rst = 1'b1;
        wb.i_wb_alu_valid   = 1'b1;
        wb.i_wb_alu_rd_addr = 5'd3;
        wb.i_wb_alu_data    = 32'h0000_0033;
        rsp(5'd5, 3'b010, 2'd0, 32'h0000_0044);
        issue(5'd9);
        #1;
        check("rst_ready", 32'(wb.o_wb_alu_ready), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        check("rst_wen", 32'(wb.o_regfile_rd_wen), 32'd0);
        check("rst_err", 32'(wb.o_wb_err), 32'd0);
        check("rst_pending", 32'(wb.o_wb_ld_pending), 32'd0);

        // Outstanding load dropped by reset; its late response flags an error but writes.
        issue(5'd9);
        tick();
        idle();
        check("rd9_pending", 32'(wb.o_wb_ld_pending), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb.i_wb_rs1_addr = 5'd9;
        #1;
        check("rd9_dropped", 32'(wb.o_wb_rs1_busy), 32'd0);
        check("rd9_no_pending", 32'(wb.o_wb_ld_pending), 32'd0);
        rsp(5'd9, 3'b010, 2'd0, 32'h0000_0099);
        tick();
        idle();
        check("late_rsp_err", 32'(wb.o_wb_err), 32'd1);
        check("late_rsp_wen", 32'(wb.o_regfile_rd_wen), 32'd1);
        check("late_rsp_data", wb.o_regfile_rd_data, 32'h0000_0099);
        wb.i_wb_rs1_addr = 5'd0;

        // Double issue to a busy rd.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(5'd15);
        tick();
        check("single_issue_ok", 32'(wb.o_wb_err), 32'd0);
        tick();
        idle();
        check("double_issue_err", 32'(wb.o_wb_err), 32'd1);
        rsp(5'd15, 3'b010, 2'd0, 32'h0000_0015);
        tick();
        idle();
        tick();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
